// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit: D-stage
// redirect select encodings and the default reset and exception addresses.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_SEQ  = 3'd0,
    NPC_BR   = 3'd1,
    NPC_J    = 3'd2,
    NPC_JR   = 3'd3,
    NPC_ERET = 3'd4
  } npc_sel_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;

endpackage : pc_pkg

// File: rtl/npc_target_calc.sv
// Combinational redirect-target calculator: branch, jump, jump-register and
// ERET targets from the D-stage instruction fields.
module npc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] pc4_d,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] epc,
  input  logic [2:0]       npc_sel,
  output logic [WIDTH-1:0] target,
  output logic             is_redirect
);

  logic [WIDTH-1:0] branch_off;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;

  assign branch_off = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign branch_tgt = pc4_d + branch_off;
  assign jump_tgt   = {pc4_d[WIDTH-1:28], imm, 2'b00};

  // is_redirect flags only the selects that may be parked while fetch stalls;
  // ERET still supplies its target here but bypasses the stall in the parent.
  // NOTE: every output is given a default first so no path can infer a latch.
  always_comb begin
    target      = pc4_d;
    is_redirect = 1'b0;
    case (npc_sel)
      NPC_BR: begin
        target      = branch_tgt;
        is_redirect = 1'b1;
      end
      NPC_J: begin
        target      = jump_tgt;
        is_redirect = 1'b1;
      end
      NPC_JR: begin
        target      = jr_target;
        is_redirect = 1'b1;
      end
      NPC_ERET: target = epc;
      default: ;
    endcase
  end

endmodule : npc_target_calc

// File: rtl/pc_unit.sv
// Fetch-stage PC register with next-PC priority logic, a one-entry buffer for
// redirects resolved while fetch is stalled, and the IF/ID flush flag.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEFAULT_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_stall,
  input  logic [2:0]       npc_sel,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] pc4_d,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             redirect,
  output logic             pending
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             redirect_q, redirect_d;

  logic [WIDTH-1:0] target;
  logic             is_redirect;

  npc_target_calc #(
    .WIDTH(WIDTH)
  ) u_target_calc (
    .imm        (imm),
    .pc4_d      (pc4_d),
    .jr_target  (jr_target),
    .epc        (epc),
    .npc_sel    (npc_sel),
    .target     (target),
    .is_redirect(is_redirect)
  );

  assign pc4 = pc_q + WIDTH'(4);

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    redirect_d    = 1'b0;

    if (exc_req) begin
      pc_d         = EXC_VECTOR;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
    end else if (npc_sel == NPC_ERET) begin
      pc_d         = target;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
    end else if (is_redirect && !if_stall) begin
      pc_d         = target;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
    end else if (is_redirect) begin
      // Park the newest target; an older parked one is stale by definition.
      pend_valid_d  = 1'b1;
      pend_target_d = target;
    end else if (pend_valid_q && !if_stall) begin
      pc_d         = pend_target_q;
      redirect_d   = 1'b1;
      pend_valid_d = 1'b0;
    end else if (!if_stall) begin
      pc_d = pc4;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      redirect_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      redirect_q   <= redirect_d;
    end
    // NOTE: the buffered target is data qualified by pend_valid_q, so it
    // carries no reset.
    pend_target_q <= pend_target_d;
  end

  assign pc       = pc_q;
  assign redirect = redirect_q;
  assign pending  = pend_valid_q;

endmodule : pc_unit

// File: doc/pc_unit.md
# pc_unit

Fetch-stage program-counter unit for the 5-stage MIPS pipeline, the parametrised successor of the combinational next-PC mux. It owns the PC register and computes sequential, branch, jump, jump-register, ERET and exception-vector targets. Redirects resolved in D while fetch is stalled are held in a one-entry pending buffer so they are never lost. It drives the instruction-memory address and the IF/ID flush request.

## Interface
- WIDTH, 32: PC/address width; must be ≥ 32.
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_VECTOR, 32'h0000_4180: exception handler entry address.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- if_stall  in  1  fetch stall (e.g. memory wait); hold PC.
- npc_sel  in  3  D-stage redirect select: 0 seq, 1 taken branch, 2 j/jal, 3 jr/jalr, 4 eret; 5–7 treated as 0.
- imm  in  26  D-stage instruction imm field (branch uses [15:0]).
- pc4_d  in  WIDTH  PC+4 of the D-stage instruction.
- jr_target  in  WIDTH  forwarded rs value.
- epc  in  WIDTH  CP0 EPC.
- exc_req  in  1  exception taken this cycle.
- pc  out  WIDTH  current fetch address (registered).
- pc4  out  WIDTH  pc + 4 (combinational).
- redirect  out  1  registered; 1 for one cycle after PC loaded from a non-sequential source (flush IF/ID).
- pending  out  1  pending-redirect buffer valid (registered).

## Operation
- Targets (WIDTH-bit, wrap mod 2^WIDTH): branch = pc4_d + (sext(imm[15:0]) << 2); jump = {pc4_d[WIDTH-1:28], imm, 2'b00}; jr = jr_target; eret = epc; exception = EXC_VECTOR.
- Next-PC priority, highest first:
  - reset → RESET_PC; pending, redirect cleared.
  - exc_req → EXC_VECTOR regardless of if_stall; pending cleared.
  - npc_sel==4 → epc regardless of if_stall; pending cleared.
  - npc_sel∈{1,2,3} with if_stall=0 → target; pending cleared.
  - npc_sel∈{1,2,3} with if_stall=1 → PC held; target written to pending buffer, overwriting any older entry.
  - pending=1, if_stall=0, no redirect → PC ← buffered target; pending cleared.
  - if_stall=1 → PC held.
  - otherwise → PC ← pc + 4.
- redirect next value = 1 exactly when PC is loaded from any non-sequential source (exception, eret, redirect, pending drain), else 0; not set for reset.
- No alignment check; low 2 bits pass through as computed.

## Timing
- Reset: pc = RESET_PC, redirect = 0, pending = 0 the cycle after reset is sampled high. Reset mid-stall or with a buffered target discards it.
- Redirect latency: inputs in cycle N → pc = target and redirect = 1 in N+1.
- Buffered redirect: captured at edge ending N (if_stall=1), pending = 1 in N+1; first cycle M with if_stall=0 → pc = target in M+1, pending = 0.
- exc_req together with npc_sel=4 → exception wins. exc_req or eret while pending=1 → buffer dropped.
- New redirect with if_stall=0 while pending=1 → new target wins, buffer dropped.
- pc4 is combinational from pc; no other combinational input-to-output path.
- PC + 4 wraps 32'hFFFF_FFFC → 0.

## Structure
- Shared package pc_pkg: npc_sel encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR, NPC_ERET), default RESET_PC and EXC_VECTOR constants.
- One combinational sub-module npc_target_calc (imm, pc4_d, jr_target, epc, npc_sel → target, is_redirect); pc_unit holds the PC register, pending buffer, priority logic and redirect flag.

## Test plan
- Reset, then 3 idle cycles → pc = 0x3000, 0x3004, 0x3008, 0x300C; redirect = 0.
- pc4_d = 0x3010, npc_sel=1, imm[15:0]=0xFFFC → next pc = 0x3000, redirect = 1 for one cycle; imm=0x0004 → 0x3020.
- npc_sel=2, pc4_d = 0x3010, imm = 26'h0000C10 → pc = 0x0000_3040; npc_sel=3, jr_target = 0x3100 → pc = 0x3100.
- if_stall=1 for 3 cycles, npc_sel=1 target 0x3200 in stall cycle 1 → pc held, pending = 1; stall drops → pc = 0x3200 next cycle, pending = 0.
- exc_req and npc_sel=4 (epc = 0x3300) together with if_stall=1 and pending=1 → pc = 0x4180, pending = 0; next cycle npc_sel=4 alone → pc = 0x3300.
- pending=1, assert reset → pc = 0x3000, pending = 0, redirect = 0; pc = 0xFFFF_FFFC, idle → wraps to 0x0.
